// File: rtl/pipe_ser_pkg.sv
// Shared definitions for the pipe serial link (transmitter and receiver).
package pipe_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } ser_state_e;

  localparam logic SER_IDLE_LVL  = 1'b1;
  localparam logic SER_START_LVL = 1'b0;
  localparam logic SER_STOP_LVL  = 1'b1;

  // Width of a counter that must hold values 0..n; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_ser_hold.sv
// One-entry holding buffer in front of the serialiser.
// o_ready is a registered copy of !full, so it never depends on i_valid.
module pipe_ser_hold
  import pipe_ser_pkg::*;
#(
  parameter int unsigned W_DATA = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_clear,
  output logic              o_full,
  output logic [W_DATA-1:0] o_data
);

  logic accept;
  logic full_next;

  // Occupancy after this edge: a new word always wins over a same-cycle drain.
  always_comb begin
    accept    = i_valid && o_ready;
    full_next = accept || (o_full && !i_clear);
  end

  // Buffer storage and registered ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_full  <= 1'b0;
      o_ready <= 1'b1;
      o_data  <= '0;
    end else begin
      o_full  <= full_next;
      o_ready <= !full_next;
      if (accept) begin
        o_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/pipe_ser_tx.sv
// Parallel-to-serial frame transmitter: start bit, data LSB first,
// optional even parity bit, stop bit, then GAP_BITS idle-high cycles.
// Build option: define PIPE_SER_TX_PARITY_EN to insert the parity bit.
module pipe_ser_tx
  import pipe_ser_pkg::*;
#(
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_ser,
  output logic              o_frame,
  output logic              o_busy
);

  localparam int unsigned W_CNT = cnt_width(W_DATA);
  localparam int unsigned W_GAP = cnt_width(GAP_BITS);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_DATA - 1);
  localparam logic [W_GAP-1:0] GAP_LAST = W_GAP'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  ser_state_e        state;
  logic [W_DATA-1:0] sh;
  logic [W_CNT-1:0]  cnt;
  logic [W_GAP-1:0]  gap_cnt;
  logic              buf_full;
  logic [W_DATA-1:0] buf_data;
  logic              load_c;

  pipe_ser_hold #(
    .W_DATA (W_DATA)
  ) u_hold (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_clear (load_c),
    .o_full  (buf_full),
    .o_data  (buf_data)
  );

  // Move the buffered word into the shifter whenever the FSM is about to start a frame.
  always_comb begin
    load_c = 1'b0;
    if (buf_full) begin
      case (state)
        IDLE:    load_c = 1'b1;
        STOP:    load_c = (GAP_BITS == 0);
        GAP:     load_c = (gap_cnt == GAP_LAST);
        default: load_c = 1'b0;
      endcase
    end
  end

`ifdef PIPE_SER_TX_PARITY_EN
  logic parity;

  // Even parity of the word, captured as it enters the shifter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      parity <= 1'b0;
    end else if (load_c) begin
      parity <= ^buf_data;
    end
  end
`endif

  // Frame FSM; the line outputs are a registered decode of the current state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      o_ser   <= SER_IDLE_LVL;
      o_frame <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_ser   <= SER_IDLE_LVL;
          o_frame <= 1'b0;
          if (load_c) begin
            sh    <= buf_data;
            state <= START;
          end
        end
        START: begin
          o_ser   <= SER_START_LVL;
          o_frame <= 1'b1;
          cnt     <= '0;
          state   <= DATA;
        end
        DATA: begin
          o_ser   <= sh[0];
          o_frame <= 1'b1;
          sh      <= sh >> 1;
          cnt     <= cnt + W_CNT'(1);
          if (cnt == CNT_LAST) begin
`ifdef PIPE_SER_TX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef PIPE_SER_TX_PARITY_EN
        PARITY: begin
          o_ser   <= parity;
          o_frame <= 1'b1;
          state   <= STOP;
        end
`endif
        STOP: begin
          o_ser   <= SER_STOP_LVL;
          o_frame <= 1'b1;
          gap_cnt <= '0;
          if (GAP_BITS != 0) begin
            state <= GAP;
          end else if (load_c) begin
            sh    <= buf_data;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          o_ser   <= SER_IDLE_LVL;
          o_frame <= 1'b0;
          gap_cnt <= gap_cnt + W_GAP'(1);
          if (gap_cnt == GAP_LAST) begin
            if (load_c) begin
              sh    <= buf_data;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          o_ser   <= SER_IDLE_LVL;
          o_frame <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE) || buf_full;

endmodule
